// File: rtl/high_score_text_gen.sv
// high_score_text_gen
// Overlays the "HIGHSCORE" banner (glyph ROM slots 3..11, 2x scale) onto the
// VGA pixel stream. Two pipeline stages line up with the registered glyph ROM.
// After a new high score the banner blinks for BLINK_FRAMES frames and then
// returns to steady display.
module high_score_text_gen #(
    parameter logic [9:0]  X_START      = 10'd256,
    parameter logic [9:0]  Y_START      = 10'd32,
    parameter logic [11:0] TEXT_RGB     = 12'hFF0,
    parameter logic [5:0]  BLINK_PERIOD = 6'd16,
    parameter logic [7:0]  BLINK_FRAMES = 8'd128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        new_high,
    input  logic        enable,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        text_on,
    output logic [11:0] rgb
);

    // Window edges kept at 11 bits so a window near the raster edge cannot wrap.
    localparam logic [10:0] X_END      = {1'b0, X_START} + 11'd144;
    localparam logic [10:0] Y_END      = {1'b0, Y_START} + 11'd32;
    localparam logic [6:0]  FIRST_CHAR = 7'd3;

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_BLINK = 1'b1
    } state_t;

    // Stage 0 (combinational) signals
    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_win;
    logic [6:0] char_idx;
    logic [3:0] row;
    logic       unused_bits;

    // Pipeline registers
    logic [2:0]  col_d1_d, col_d1_q;
    logic        win_d1_d, win_d1_q;
    logic        text_on_d, text_on_q;
    logic [11:0] rgb_d, rgb_q;
    logic        pix_bit;

    // Blink controller registers
    state_t      state_d, state_q;
    logic        visible_d, visible_q;
    logic [7:0]  frame_cnt_d, frame_cnt_q;
    logic [5:0]  period_cnt_d, period_cnt_q;

    // Stage 0: window decode and glyph ROM address generation
    always_comb begin
        dx       = x - X_START;
        dy       = y - Y_START;
        char_idx = FIRST_CHAR + {1'b0, dx[9:4]};
        row      = dy[4:1];
        if (video_on
            && ({1'b0, x} >= {1'b0, X_START}) && ({1'b0, x} < X_END)
            && ({1'b0, y} >= {1'b0, Y_START}) && ({1'b0, y} < Y_END)) begin
            in_win = 1'b1;
        end else begin
            in_win = 1'b0;
        end
        if (in_win) begin
            rom_addr = {char_idx, row};
        end else begin
            rom_addr = 11'h000;
        end
        // Sub-pixel and high-order offset bits are not needed at 2x scale.
        unused_bits = ^{dx[0], dy[9:5], dy[0]};
    end

    // Stage 1/2 next values: carry column/window alongside the ROM, then pick the glyph bit
    always_comb begin
        col_d1_d  = dx[3:1];
        win_d1_d  = in_win;
        pix_bit   = rom_data[3'd7 - col_d1_q];
        text_on_d = win_d1_q & pix_bit & enable & visible_q;
        if (text_on_d) begin
            rgb_d = TEXT_RGB;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Pixel pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_d1_q  <= 3'd0;
            win_d1_q  <= 1'b0;
            text_on_q <= 1'b0;
            rgb_q     <= 12'h000;
        end else begin
            col_d1_q  <= col_d1_d;
            win_d1_q  <= win_d1_d;
            text_on_q <= text_on_d;
            rgb_q     <= rgb_d;
        end
    end

    // Blink controller next-state: new_high restarts, frame_tick advances counters
    always_comb begin
        state_d      = state_q;
        visible_d    = visible_q;
        frame_cnt_d  = frame_cnt_q;
        period_cnt_d = period_cnt_q;
        case (state_q)
            ST_SHOW: begin
                if (new_high) begin
                    state_d      = ST_BLINK;
                    visible_d    = 1'b0;
                    frame_cnt_d  = 8'd0;
                    period_cnt_d = 6'd0;
                end else begin
                    visible_d    = 1'b1;
                end
            end
            ST_BLINK: begin
                if (new_high) begin
                    visible_d    = 1'b0;
                    frame_cnt_d  = 8'd0;
                    period_cnt_d = 6'd0;
                end else if (frame_tick) begin
                    if (frame_cnt_q == (BLINK_FRAMES - 8'd1)) begin
                        state_d      = ST_SHOW;
                        visible_d    = 1'b1;
                        frame_cnt_d  = 8'd0;
                        period_cnt_d = 6'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        if (period_cnt_q == (BLINK_PERIOD - 6'd1)) begin
                            period_cnt_d = 6'd0;
                            visible_d    = ~visible_q;
                        end else begin
                            period_cnt_d = period_cnt_q + 6'd1;
                        end
                    end
                end else begin
                    visible_d = visible_q;
                end
            end
            default: begin
                state_d      = ST_SHOW;
                visible_d    = 1'b1;
                frame_cnt_d  = 8'd0;
                period_cnt_d = 6'd0;
            end
        endcase
    end

    // Blink controller state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_SHOW;
            visible_q    <= 1'b1;
            frame_cnt_q  <= 8'd0;
            period_cnt_q <= 6'd0;
        end else begin
            state_q      <= state_d;
            visible_q    <= visible_d;
            frame_cnt_q  <= frame_cnt_d;
            period_cnt_q <= period_cnt_d;
        end
    end

    assign text_on = text_on_q;
    assign rgb     = rgb_q;

endmodule

// File: tb/tb_high_score_text_gen.sv
// Self-checking bench for high_score_text_gen: directed vector table,
// hand-written blink sequences and a randomized run against a frame-level model.
module tb_high_score_text_gen;

    localparam int XS = 256;
    localparam int YS = 32;
    localparam int P  = 16;
    localparam int F  = 128;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        frame_tick;
    logic        new_high;
    logic        enable;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        text_on;
    logic [11:0] rgb;

    logic [7:0] rom [0:2047];

    int n_checks = 0;
    int n_pass   = 0;

    high_score_text_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .new_high   (new_high),
        .enable     (enable),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .text_on    (text_on),
        .rgb        (rgb)
    );

    always #5 clk = ~clk;

    // Glyph ROM model: registers the address, data valid one clock later
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        int          px;
        int          py;
        bit          v;
        bit          en;
        logic [10:0] addr;
        bit          lit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input bit exp_lit);
        check({name, "_text_on"}, {31'd0, text_on}, {31'd0, exp_lit});
        check({name, "_rgb"}, {20'd0, rgb}, exp_lit ? 32'h0000_0FF0 : 32'h0);
    endtask

    function automatic bit in_window(int px, int py, bit v);
        return v && px >= XS && px < XS + 144 && py >= YS && py < YS + 32;
    endfunction

    function automatic logic [10:0] ref_addr(int px, int py, bit v);
        if (!in_window(px, py, v)) return 11'h000;
        return 11'((3 + (px - XS) / 16) * 16 + (py - YS) / 2);
    endfunction

    function automatic bit ref_pix(int px, int py, bit v);
        logic [7:0] b;
        int col;
        if (!in_window(px, py, v)) return 1'b0;
        b   = rom[ref_addr(px, py, v)];
        col = ((px - XS) % 16) / 2;
        return b[7 - col];
    endfunction

    task automatic set_pix(input int px, input int py, input bit v, input bit en);
        x = 10'(px);
        y = 10'(py);
        video_on = v;
        enable = en;
    endtask

    task automatic tick_and_settle();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
    endtask

    task automatic pulse_new_high();
        new_high = 1'b1;
        step();
        new_high = 1'b0;
        step();
        step();
    endtask

    // random-run model state
    bit in_blink;
    int k;
    bit prev_pix;
    bit prev_vis;

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 8'((i * 73 + 29) ^ (i >> 2));
        rom[0]      = 8'h00;
        rom[11'h032] = 8'hC6;
        rom[11'h0B4] = 8'h01;
        rom[11'h03F] = 8'h80;

        vecs.push_back('{256, 36, 1'b1, 1'b1, 11'h032, 1'b1});
        vecs.push_back('{262, 36, 1'b1, 1'b1, 11'h032, 1'b0});
        vecs.push_back('{257, 36, 1'b1, 1'b1, 11'h032, 1'b1});
        vecs.push_back('{258, 36, 1'b1, 1'b1, 11'h032, 1'b1});
        vecs.push_back('{260, 36, 1'b1, 1'b1, 11'h032, 1'b0});
        vecs.push_back('{399, 40, 1'b1, 1'b1, 11'h0B4, 1'b1});
        vecs.push_back('{400, 40, 1'b1, 1'b1, 11'h000, 1'b0});
        vecs.push_back('{256, 36, 1'b0, 1'b1, 11'h000, 1'b0});
        vecs.push_back('{300, 50, 1'b0, 1'b1, 11'h000, 1'b0});
        vecs.push_back('{255, 36, 1'b1, 1'b1, 11'h000, 1'b0});
        vecs.push_back('{256, 31, 1'b1, 1'b1, 11'h000, 1'b0});
        vecs.push_back('{256, 63, 1'b1, 1'b1, 11'h03F, 1'b1});
        vecs.push_back('{256, 64, 1'b1, 1'b1, 11'h000, 1'b0});
        vecs.push_back('{256, 36, 1'b1, 1'b0, 11'h032, 1'b0});

        reset_n = 1'b0;
        set_pix(256, 36, 1'b1, 1'b1);
        frame_tick = 1'b0;
        new_high = 1'b0;
        step();
        step();
        check_out("reset", 1'b0);
        reset_n = 1'b1;

        // Directed vectors, each held for the full two-stage latency
        foreach (vecs[i]) begin
            set_pix(vecs[i].px, vecs[i].py, vecs[i].v, vecs[i].en);
            #1;
            check($sformatf("vec%0d_addr", i), {21'd0, rom_addr}, {21'd0, vecs[i].addr});
            step();
            step();
            check_out($sformatf("vec%0d", i), vecs[i].lit);
        end

        // Full blink episode on a lit pixel
        set_pix(256, 36, 1'b1, 1'b1);
        pulse_new_high();
        check_out("blink_start", 1'b0);
        for (int t = 1; t <= F; t++) begin
            tick_and_settle();
            check_out($sformatf("blink_t%0d", t), (t >= F) ? 1'b1 : (((t / P) % 2) == 1));
        end
        for (int t = 0; t < 20; t++) tick_and_settle();
        check_out("show_ticks_ignored", 1'b1);

        // new_high with simultaneous frame_tick restarts the episode
        pulse_new_high();
        for (int t = 0; t < 20; t++) tick_and_settle();
        check_out("restart_pre", 1'b1);
        new_high = 1'b1;
        frame_tick = 1'b1;
        step();
        new_high = 1'b0;
        frame_tick = 1'b0;
        step();
        step();
        check_out("restart_prio", 1'b0);
        for (int t = 0; t < 15; t++) tick_and_settle();
        check_out("restart_15", 1'b0);
        tick_and_settle();
        check_out("restart_16", 1'b1);

        // Reset in the middle of a blink episode
        pulse_new_high();
        check_out("midreset_pre", 1'b0);
        reset_n = 1'b0;
        step();
        check_out("midreset_in", 1'b0);
        set_pix(272, 36, 1'b1, 1'b1);
        #1;
        check("midreset_addr", {21'd0, rom_addr}, 32'h042);
        set_pix(256, 36, 1'b1, 1'b1);
        step();
        check_out("midreset_hold", 1'b0);
        reset_n = 1'b1;
        step();
        step();
        check_out("midreset_after", 1'b1);

        // Randomized run against the frame-level model
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        in_blink = 1'b0;
        k = 0;
        prev_pix = 1'b0;
        prev_vis = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit rst_in;
            bit nh;
            bit ft;
            bit en;
            bit cur_pix;
            bit exp_lit;
            int px;
            int py;
            bit v;
            rst_in = ($urandom_range(0, 499) != 0);
            px = $urandom_range(240, 420);
            py = $urandom_range(20, 80);
            v  = ($urandom_range(0, 9) != 0);
            en = ($urandom_range(0, 9) != 0);
            ft = ($urandom_range(0, 3) == 0);
            nh = ($urandom_range(0, 299) == 0);
            reset_n = rst_in;
            set_pix(px, py, v, en);
            frame_tick = ft;
            new_high = nh;
            #1;
            check($sformatf("rand%0d_addr", i), {21'd0, rom_addr}, {21'd0, ref_addr(px, py, v)});
            cur_pix = ref_pix(px, py, v);
            @(posedge clk);
            #1;
            if (!rst_in) begin
                exp_lit  = 1'b0;
                prev_pix = 1'b0;
                prev_vis = 1'b1;
                in_blink = 1'b0;
                k = 0;
            end else begin
                exp_lit = prev_pix & en & prev_vis;
                if (nh) begin
                    in_blink = 1'b1;
                    k = 0;
                end else if (ft && in_blink) begin
                    k++;
                    if (k == F) in_blink = 1'b0;
                end
                prev_vis = !in_blink || (((k / P) % 2) == 1);
                prev_pix = cur_pix;
            end
            check_out($sformatf("rand%0d", i), exp_lit);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/high_score_text_gen.md
HIGH_SCORE_TEXT_GEN -- requirements
Module: high_score_text_gen

Interface
REQ-001 Parameter X_START, default 10'd256, left pixel column of the text window.
REQ-002 Parameter Y_START, default 10'd32, top pixel row of the text window.
REQ-003 Parameter TEXT_RGB, default 12'hFF0, colour of lit glyph pixels.
REQ-004 Parameter BLINK_PERIOD, default 6'd16, frames per visibility toggle while blinking.
REQ-005 Parameter BLINK_FRAMES, default 8'd128, total frames a blink episode lasts.
REQ-006 clk  input  1  single system/pixel clock; all logic on rising edge.
REQ-007 reset_n  input  1  reset, synchronous, active-low.
REQ-008 x  input  10  current pixel column from the VGA sync generator.
REQ-009 y  input  10  current pixel row from the VGA sync generator.
REQ-010 video_on  input  1  active-display flag aligned with x/y.
REQ-011 frame_tick  input  1  one-cycle pulse once per frame.
REQ-012 new_high  input  1  one-cycle pulse: a new high score was set; starts blinking.
REQ-013 enable  input  1  text overlay enable; 0 suppresses all text pixels.
REQ-014 rom_addr  output  11  address to the glyph ROM: {char_idx[6:0], row[3:0]}.
REQ-015 rom_data  input  8  glyph row from the ROM, valid one clock after rom_addr (ROM registers the address); bit 7 = leftmost pixel.
REQ-016 text_on  output  1  registered: current aligned pixel is a lit glyph pixel.
REQ-017 rgb  output  12  registered: TEXT_RGB when text_on, else 12'h000.

Function
REQ-018 Message = ROM glyph slots 3..11 ("HIGHSCORE"), 9 characters, drawn at 2x scale: each glyph cell 16 px wide x 32 px high; window 144 x 32 px.
REQ-019 In-window (stage 0, combinational): video_on=1 and X_START <= x < X_START+144 and Y_START <= y < Y_START+32.
REQ-020 Address (stage 0, combinational): dx = x-X_START, dy = y-Y_START (10-bit unsigned); char_idx = 3 + dx[9:4]; row = dy[4:1]; rom_addr = {char_idx, row}.
REQ-021 Outside the window rom_addr SHALL be 11'h000 (blank glyph).
REQ-022 Stage 1 register: col_d1 = dx[3:1], win_d1 = in-window, captured each clock alongside the ROM's address register.
REQ-023 Stage 2 register: text_on <= win_d1 & rom_data[7-col_d1] & enable & visible; rgb per REQ-017.
REQ-024 Latency: x/y/video_on sampled at cycle N produce text_on/rgb at cycle N+2; no stalls, one pixel per clock.
REQ-025 FSM states: SHOW (visible=1) and BLINK.
REQ-026 SHOW -> BLINK on new_high=1; on entry frame_cnt=0, period_cnt=0, visible=0.
REQ-027 In BLINK, on each frame_tick: frame_cnt+1, period_cnt+1; when period_cnt reaches BLINK_PERIOD-1 it wraps to 0 and visible toggles.
REQ-028 BLINK -> SHOW on the frame_tick at which frame_cnt reaches BLINK_FRAMES-1; visible forced to 1.
REQ-029 new_high in BLINK restarts the episode (counters to 0, visible=0); new_high has priority over a simultaneous frame_tick.
REQ-030 frame_tick in SHOW has no effect; counters hold.
REQ-031 enable=0 forces text_on=0 and rgb=0 at stage 2 but does not stop the FSM or counters.
REQ-032 Counters saturate-free: frame_cnt 8 bits, period_cnt 6 bits; BLINK_PERIOD >= 1 and BLINK_FRAMES >= 1 required.

Reset
REQ-033 While reset_n=0 at a clock edge: text_on=0, rgb=12'h000, col_d1=0, win_d1=0, FSM=SHOW, visible=1, frame_cnt=0, period_cnt=0.
REQ-034 Reset mid-BLINK returns to SHOW immediately; first valid output 2 cycles after reset_n rises.
REQ-035 rom_addr is combinational and follows x/y during reset.

Verification
REQ-036 x=256,y=36,video_on=1 -> rom_addr=11'h032 (H, row 2); 2 cycles later text_on=1, rgb=12'hFF0 (rom_data=8'hC6, col 0).
REQ-037 x=262,y=36 (col 3, H row 2 = 8'hC6 bit 4 = 0) -> text_on=0, rgb=0 at N+2.
REQ-038 x=399 vs x=400, y=40 -> rom_addr char_idx 11 (E) then 11'h000; text_on=0 for x=400 and for video_on=0 anywhere.
REQ-039 new_high pulse, then 128 frame_ticks with defaults -> visible toggles after ticks 16,32,...,112 (starting 0), FSM=SHOW with visible=1 after tick 128.
REQ-040 new_high and frame_tick in the same cycle during BLINK -> counters 0, visible=0; reset_n=0 mid-blink -> SHOW, visible=1, outputs 0.
